// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory bridge:
//               FSM state encoding, MMIO register offsets and the poison
//               value returned on misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   // Access sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   // Byte offsets of the registers inside the MMIO window
   localparam logic [3:0] MMIO_OUT_OFS = 4'h0;
   localparam logic [3:0] MMIO_CYC_OFS = 4'h4;

   // Read data returned for a trapped (misaligned) access
   localparam logic [31:0] c_POISON = 32'hDEAD_BEEF;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/mmio_regs.sv
`default_nettype none
// ============================================================================
// Module      : mmio_regs
// Description : MMIO register file of the data-memory bridge. Holds the
//               read/write OUT register, the free-running read-only CYC
//               counter and the read mux for the 16-byte MMIO window.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_regs
   import dmem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sel_i,   // address lies inside the MMIO window
   input  logic [3:0]  ofs_i,   // byte offset inside the window
   input  logic        we_i,    // qualified store strobe
   input  logic [31:0] wd_i,
   output logic        hit_o,   // offset maps to an implemented register
   output logic [31:0] rd_o,
   output logic [31:0] out_o
);

   logic [31:0] out_q, out_d;
   logic [31:0] cyc_q, cyc_d;
   logic        w_hit_out;
   logic        w_hit_cyc;

   // Register select decode
   always_comb begin
      w_hit_out = sel_i & (ofs_i == MMIO_OUT_OFS);
      w_hit_cyc = sel_i & (ofs_i == MMIO_CYC_OFS);
      hit_o     = w_hit_out | w_hit_cyc;
   end

   // Next-state: OUT loads on a store, CYC always counts (writes ignored, wraps)
   always_comb begin
      out_d = out_q;
      if (we_i && w_hit_out) begin
         out_d = wd_i;
      end
      cyc_d = cyc_q + 32'd1;
   end

   // Register update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q <= '0;
         cyc_q <= '0;
      end else begin
         out_q <= out_d;
         cyc_q <= cyc_d;
      end
   end

   // Read mux; holes in the window read as zero
   always_comb begin
      rd_o = '0;
      if (w_hit_out) begin
         rd_o = out_q;
      end else if (w_hit_cyc) begin
         rd_o = cyc_q;
      end
   end

   assign out_o = out_q;

endmodule : mmio_regs
`default_nettype wire

// File: rtl/dmem_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bridge
// Description : Data-side memory stage for the MIPS core. Word-addressed RAM
//               with WAIT_CYCLES of access latency (combinational stall back
//               to the core), plus a small MMIO window (OUT register and a
//               free-running cycle counter).
//               Optional build macro DMEM_MISALIGN_TRAP_EN: accesses with
//               a[1:0] != 0 are trapped (no write, poison read data, sticky
//               err). Without it a[1:0] is ignored and err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bridge
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        stall,
   output logic [31:0] mmio_out,
   output logic        err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // The counter only ever holds values up to WAIT_CYCLES-1
   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   // 33 bits so that the RAM byte size never overflows the compare
   localparam logic [32:0] c_RAM_BYTES = 33'(DEPTH) * 33'd4;
   localparam bit          c_HAS_WAIT  = (WAIT_CYCLES > 0);

   dmem_state_t   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          w_req;
   logic          w_is_ram;
   logic          w_is_mmio;
   logic          w_misaligned;
   logic          w_ram_req;
   logic          w_ram_we;
   logic          w_mmio_we;
   logic          w_mmio_hit;
   logic [31:0]   w_mmio_rd;
   logic [3:0]    w_ofs;
   logic [AW-1:0] w_idx;

   logic [31:0]   mem_q [DEPTH];

   // Request and address decode
   always_comb begin
      w_req     = we | re;
      w_is_ram  = ({1'b0, a} < c_RAM_BYTES);
      w_is_mmio = (a[31:4] == MMIO_BASE[31:4]);
      w_idx     = a[AW+1:2];
      // Byte lane bits never select a register; the window is word-granular
      w_ofs     = {a[3:2], 2'b00};
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   logic err_q, err_d;

   assign w_misaligned = w_req & (a[1:0] != 2'b00);

   // Sticky error: once a misaligned request is seen it holds until reset
   always_comb begin
      err_d = err_q | w_misaligned;
   end

   // Error flag register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   logic w_unused_lsb;

   assign w_misaligned = 1'b0;
   assign w_unused_lsb = ^a[1:0];
   assign err          = 1'b0;
`endif

   assign w_ram_req = w_req & w_is_ram & ~w_misaligned;

   // Stall covers the IDLE and WAIT cycles of a RAM access; DONE is the
   // completion cycle. Forced low while reset is asserted.
   assign stall = w_ram_req & c_HAS_WAIT & (state_q != DONE) & ~reset;

   // A store commits only on the edge that ends the non-stalled cycle
   assign w_ram_we  = we & w_is_ram & ~w_misaligned & ~stall & ~reset;
   assign w_mmio_we = we & w_is_mmio & ~w_is_ram & ~w_misaligned;

   // Sequencer next-state. The counter tracks remaining stalled cycles after
   // the current one: the IDLE cycle is the first stalled cycle, so WAIT is
   // occupied WAIT_CYCLES-1 cycles and a single-cycle wait goes straight to
   // DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (w_ram_req && c_HAS_WAIT) begin
               if (WAIT_CYCLES == 1) begin
                  state_d = DONE;
                  cnt_d   = '0;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CW'(WAIT_CYCLES - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q <= CW'(1)) begin
               state_d = DONE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // RAM array write port (contents deliberately not reset)
   always_ff @(posedge clk) begin
      if (w_ram_we) begin
         mem_q[w_idx] <= wd;
      end
   end

   mmio_regs u_mmio_regs (
      .clk   (clk),
      .reset (reset),
      .sel_i (w_is_mmio & ~w_is_ram),
      .ofs_i (w_ofs),
      .we_i  (w_mmio_we),
      .wd_i  (wd),
      .hit_o (w_mmio_hit),
      .rd_o  (w_mmio_rd),
      .out_o (mmio_out)
   );

   // Read data mux; a write-with-read still returns the old contents
   always_comb begin
      rd = '0;
      if (w_misaligned) begin
         rd = c_POISON;
      end else if (w_is_ram) begin
         rd = mem_q[w_idx];
      end else if (w_mmio_hit) begin
         rd = w_mmio_rd;
      end
   end

endmodule : dmem_bridge
`default_nettype wire
